// File: rtl/grf_bank.sv
// grf_bank: 32x32 general register file with a committed-write counter and a
// registered write-back trace record. Register 0 is hard-wired to zero.
// Optional macro GRF_BYPASS_EN enables same-cycle write-through forwarding
// on both read ports; without it reads return stored contents only.
module grf_bank #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regWrite_D_i,
  input  logic [4:0]           A3_D_i,
  input  logic [31:0]          WD_D_i,
  input  logic [31:0]          PC_GRF_W,
  input  logic [4:0]           A1_D,
  input  logic [4:0]           A2_D,
  output logic [31:0]          RD1_D,
  output logic [31:0]          RD2_D,
  output logic [CNT_WIDTH-1:0] write_cnt,
  output logic                 trace_valid,
  output logic [31:0]          trace_pc,
  output logic [4:0]           trace_reg,
  output logic [31:0]          trace_data
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic [DW-1:0]        regs_q [NREG];
  logic [DW-1:0]        regs_d [NREG];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tvalid_q, tvalid_d;
  logic [DW-1:0]        tpc_q, tpc_d;
  logic [AW-1:0]        treg_q, treg_d;
  logic [DW-1:0]        tdata_q, tdata_d;
  logic                 wr_en_c;

  // A write commits only when enabled and not targeting register 0
  assign wr_en_c = regWrite_D_i && (A3_D_i != AW'(0));

  // Next-state for register array, counter and trace record
  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    tvalid_d = 1'b0;
    tpc_d    = tpc_q;
    treg_d   = treg_q;
    tdata_d  = tdata_q;
    if (wr_en_c) begin
      regs_d[A3_D_i] = WD_D_i;
      cnt_d          = cnt_q + CNT_WIDTH'(1);
      tvalid_d       = 1'b1;
      tpc_d          = PC_GRF_W;
      treg_d         = A3_D_i;
      tdata_d        = WD_D_i;
    end
    regs_d[0] = '0;
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q   <= '{default: '0};
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tpc_q    <= '0;
      treg_q   <= '0;
      tdata_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tpc_q    <= tpc_d;
      treg_q   <= treg_d;
      tdata_q  <= tdata_d;
    end
  end

  // Combinational read ports; index 0 always yields zero
  always_comb begin
    RD1_D = (A1_D == AW'(0)) ? '0 : regs_q[A1_D];
    RD2_D = (A2_D == AW'(0)) ? '0 : regs_q[A2_D];
`ifdef GRF_BYPASS_EN
    if (wr_en_c && (A3_D_i == A1_D)) RD1_D = WD_D_i;
    if (wr_en_c && (A3_D_i == A2_D)) RD2_D = WD_D_i;
`else
`endif
  end

  assign write_cnt   = cnt_q;
  assign trace_valid = tvalid_q;
  assign trace_pc    = tpc_q;
  assign trace_reg   = treg_q;
  assign trace_data  = tdata_q;

endmodule
